// File: rtl/audio_pkg.sv
`default_nettype none
// ============================================================
// audio_pkg : shared widths and encodings for the tone player
// Revision  : 1.0
// ============================================================
package audio_pkg;

  localparam int SAMPLE_W = 5;

  typedef enum logic [1:0] {
    WAVE_SQUARE = 2'b00,
    WAVE_TRI    = 2'b01,
    WAVE_SAW    = 2'b10,
    WAVE_SILENT = 2'b11
  } wave_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/wave_shaper.sv
`default_nettype none
// ============================================================
// wave_shaper : top phase bits + waveform select -> duty sample
// Revision    : 1.0
// ============================================================
module wave_shaper #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W
) (
  input  logic [SAMPLE_W:0]   i_phase_hi,
  input  logic [1:0]          i_wave_sel,
  output logic [SAMPLE_W-1:0] o_sample
);
  import audio_pkg::*;

  logic                w_half;
  logic [SAMPLE_W-1:0] w_q;

  assign w_half = i_phase_hi[SAMPLE_W];
  assign w_q    = i_phase_hi[SAMPLE_W-1:0];

  // Falling half of the triangle is max - q, which is simply ~q.
  always_comb begin
    o_sample = '0;
    case (i_wave_sel)
      WAVE_SQUARE: o_sample = {SAMPLE_W{w_half}};
      WAVE_TRI:    o_sample = w_half ? ~w_q : w_q;
      WAVE_SAW:    o_sample = i_phase_hi[SAMPLE_W:1];
      default:     o_sample = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/tone_sample_player.sv
`default_nettype none
// ============================================================
// tone_sample_player : phase-accumulator tone source feeding PWM refs
// Revision           : 1.0
// ============================================================
module tone_sample_player #(
  parameter int SAMPLE_W = audio_pkg::SAMPLE_W,
  parameter int PHASE_W  = 16,
  parameter int DUR_W    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick,
  input  logic                start,
  input  logic [PHASE_W-1:0]  step,
  input  logic [DUR_W-1:0]    duration,
  input  logic [1:0]          wave_sel,
  output logic                busy,
  output logic                done,
  output logic [SAMPLE_W-1:0] pwm_ref,
  output logic                sample_strobe
);
  import audio_pkg::*;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [SAMPLE_W-1:0]  r_slot;
  logic [PHASE_W-1:0]   r_phase;
  logic [PHASE_W-1:0]   w_phase_nxt;
  logic [PHASE_W-1:0]   r_step;
  logic [PHASE_W-1:0]   w_step_nxt;
  logic [DUR_W-1:0]     r_remaining;
  logic [DUR_W-1:0]     w_remaining_nxt;
  logic [1:0]           r_wave;
  logic [1:0]           w_wave_nxt;
  logic [SAMPLE_W-1:0]  r_pwm_ref;
  logic [SAMPLE_W-1:0]  w_pwm_nxt;
  logic                 r_strobe;
  logic                 w_strobe_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_boundary;
  logic [SAMPLE_W-1:0]  w_sample;

  // Slot mirrors the PWM counter, so its wrap marks the PWM period edge.
  assign w_boundary = tick && (r_slot == {SAMPLE_W{1'b1}});

  wave_shaper #(
    .SAMPLE_W (SAMPLE_W)
  ) u_wave_shaper (
    .i_phase_hi (r_phase[PHASE_W-1 -: SAMPLE_W+1]),
    .i_wave_sel (r_wave),
    .o_sample   (w_sample)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_phase_nxt     = r_phase;
    w_step_nxt      = r_step;
    w_remaining_nxt = r_remaining;
    w_wave_nxt      = r_wave;
    w_pwm_nxt       = r_pwm_ref;
    w_strobe_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_pwm_nxt = '0;
        if (start) begin
          w_state_nxt     = ST_PLAY;
          w_step_nxt      = step;
          w_remaining_nxt = duration;
          w_wave_nxt      = wave_sel;
          w_phase_nxt     = '0;
        end
      end
      ST_PLAY: begin
        if (w_boundary) begin
          if (r_remaining == '0) begin
            w_state_nxt = ST_DONE;
            w_pwm_nxt   = '0;
          end else begin
            w_pwm_nxt       = w_sample;
            w_strobe_nxt    = 1'b1;
            w_phase_nxt     = r_phase + r_step;
            w_remaining_nxt = r_remaining - DUR_W'(1);
          end
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot      <= '0;
      r_phase     <= '0;
      r_step      <= '0;
      r_remaining <= '0;
      r_wave      <= '0;
      r_pwm_ref   <= '0;
      r_strobe    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (tick) begin
        r_slot <= r_slot + SAMPLE_W'(1);
      end
      r_phase     <= w_phase_nxt;
      r_step      <= w_step_nxt;
      r_remaining <= w_remaining_nxt;
      r_wave      <= w_wave_nxt;
      r_pwm_ref   <= w_pwm_nxt;
      r_strobe    <= w_strobe_nxt;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_done      <= (w_state_nxt == ST_DONE);
    end
  end

  assign busy          = r_busy;
  assign done          = r_done;
  assign pwm_ref       = r_pwm_ref;
  assign sample_strobe = r_strobe;

endmodule
`default_nettype wire

// File: tb/tb_tone_sample_player.sv
`default_nettype none
// Bench for tone_sample_player: table of directed tones plus start/reset corner sequences.
module tb_tone_sample_player;
  import audio_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        start = 1'b0;
  logic [15:0] step = '0;
  logic [15:0] duration = '0;
  logic [1:0]  wave_sel = '0;
  logic        busy;
  logic        done;
  logic [4:0]  pwm_ref;
  logic        sample_strobe;

  tone_sample_player #(
    .SAMPLE_W (5),
    .PHASE_W  (16),
    .DUR_W    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .start         (start),
    .step          (step),
    .duration      (duration),
    .wave_sel      (wave_sel),
    .busy          (busy),
    .done          (done),
    .pwm_ref       (pwm_ref),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [4:0] m_slot = '0;
  int         tick_total = 0;
  bit         edge_bnd = 1'b0;
  int         sq_val[$];
  int         sq_tick[$];
  bit         sq_bnd[$];

  typedef struct {
    string       name;
    logic [1:0]  wave;
    logic [15:0] stp;
    logic [15:0] dur;
    int          n;
    int          exp_v[20];
  } vec_t;

  vec_t vecs[8];

  // tick: one pulse every 4 clocks, changed on the falling edge
  initial begin
    int tdiv;
    tdiv = 0;
    forever begin
      @(negedge clk);
      tdiv = (tdiv + 1) % 4;
      tick = (tdiv == 0);
    end
  end

  // observer: independent slot model and strobe log
  initial begin
    forever begin
      @(posedge clk);
      edge_bnd = !reset && tick && (m_slot == 5'd31);
      if (reset) m_slot = '0;
      else if (tick) m_slot = m_slot + 5'd1;
      if (!reset && tick) tick_total++;
      #1;
      if (sample_strobe) begin
        sq_val.push_back(int'(pwm_ref));
        sq_tick.push_back(tick_total);
        sq_bnd.push_back(edge_bnd);
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_tone(input int vi, input bit mid_start, input bit align);
    vec_t v;
    int   start_tick;
    int   waited;
    int   limit;
    int   g;
    int   lat;
    bit   got_done;
    bit   mid_done;
    v = vecs[vi];
    sq_val.delete();
    sq_tick.delete();
    sq_bnd.delete();
    g = 0;
    if (align) begin
      do begin
        @(negedge clk);
        #1;
        g++;
      end while (!(tick && m_slot == 5'd31) && g < 400);
      check({v.name, " align found"}, (g < 400), 1);
    end else begin
      @(negedge clk);
      #1;
    end
    wave_sel = v.wave;
    step     = v.stp;
    duration = v.dur;
    start    = 1'b1;
    @(posedge clk);
    #2;
    start_tick = tick_total;
    check({v.name, " busy rise"}, busy, 1);
    @(negedge clk);
    #1;
    start    = 1'b0;
    step     = 16'hFFFF;
    duration = 16'd3;
    wave_sel = WAVE_SILENT;
    limit    = (int'(v.dur) + 2) * 128 + 64;
    waited   = 0;
    got_done = 1'b0;
    mid_done = 1'b0;
    while (!got_done && waited < limit) begin
      @(posedge clk);
      #2;
      waited++;
      if (done) begin
        got_done = 1'b1;
      end else if (mid_start && !mid_done && sq_val.size() >= 2) begin
        mid_done = 1'b1;
        @(negedge clk);
        #1;
        start    = 1'b1;
        step     = 16'h1000;
        wave_sel = WAVE_SAW;
        duration = 16'd2;
        @(negedge clk);
        #1;
        start = 1'b0;
      end
    end
    check({v.name, " done seen"}, got_done, 1);
    if (got_done) begin
      check({v.name, " busy at done"}, busy, 1);
      check({v.name, " done on boundary"}, edge_bnd, 1);
      check({v.name, " strobe count"}, sq_val.size(), v.n);
      for (int i = 0; i < v.n && i < sq_val.size(); i++) begin
        check($sformatf("%s sample[%0d]", v.name, i), sq_val[i], v.exp_v[i]);
        check($sformatf("%s strobe[%0d] on boundary", v.name, i), sq_bnd[i], 1);
        if (i > 0)
          check($sformatf("%s spacing[%0d]", v.name, i), sq_tick[i] - sq_tick[i-1], 32);
      end
      if (sq_val.size() > 0) begin
        lat = sq_tick[0] - start_tick;
        if (align) check({v.name, " first latency"}, lat, 32);
        else check({v.name, " first latency in 1..32"}, (lat >= 1 && lat <= 32), 1);
        check({v.name, " done after last"}, tick_total - sq_tick[sq_tick.size()-1], 32);
      end else begin
        lat = tick_total - start_tick;
        check({v.name, " done latency in 1..32"}, (lat >= 1 && lat <= 32), 1);
      end
      @(posedge clk);
      #2;
      check({v.name, " done single"}, done, 0);
      check({v.name, " busy fall"}, busy, 0);
      check({v.name, " ref after"}, pwm_ref, 0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int g;
    vecs[0] = '{"square", WAVE_SQUARE, 16'h4000, 16'd8, 8,
                '{0,0,31,31,0,0,31,31,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[1] = '{"triangle", WAVE_TRI, 16'h0800, 16'd20, 20,
                '{0,2,4,6,8,10,12,14,16,18,20,22,24,26,28,30,31,29,27,25}};
    vecs[2] = '{"saw", WAVE_SAW, 16'h0800, 16'd4, 4,
                '{0,1,2,3,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[3] = '{"saw_wrap", WAVE_SAW, 16'hC000, 16'd4, 4,
                '{0,24,16,8,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[4] = '{"silence", WAVE_SILENT, 16'h1234, 16'd3, 3,
                '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[5] = '{"tri_big", WAVE_TRI, 16'h5000, 16'd4, 4,
                '{0,20,23,3,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[6] = '{"square_half", WAVE_SQUARE, 16'h8000, 16'd3, 3,
                '{0,31,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};
    vecs[7] = '{"dur0", WAVE_SQUARE, 16'h4000, 16'd0, 0,
                '{0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0,0}};

    repeat (3) @(posedge clk);
    #2;
    check("reset pwm_ref", pwm_ref, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset strobe", sample_strobe, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #2;
      if (busy || done || sample_strobe || pwm_ref != 5'd0) bad++;
    end
    check("idle quiet cycles", bad, 0);

    for (int vi = 0; vi < 8; vi++) run_tone(vi, 1'b0, 1'b0);

    run_tone(0, 1'b1, 1'b0);
    run_tone(2, 1'b0, 1'b1);

    // reset in the middle of a triangle tone
    sq_val.delete();
    sq_tick.delete();
    sq_bnd.delete();
    @(negedge clk);
    #1;
    wave_sel = WAVE_TRI;
    step     = 16'h0800;
    duration = 16'd20;
    start    = 1'b1;
    @(negedge clk);
    #1;
    start = 1'b0;
    g = 0;
    while (sq_val.size() < 3 && g < 1000) begin
      @(posedge clk);
      #2;
      g++;
    end
    check("midreset strobes seen", (sq_val.size() >= 3), 1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #2;
    check("midreset pwm_ref", pwm_ref, 0);
    check("midreset busy", busy, 0);
    check("midreset done", done, 0);
    check("midreset strobe", sample_strobe, 0);
    @(negedge clk);
    #1;
    reset = 1'b0;

    run_tone(1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tone_sample_player.md
# tone_sample_player

Upstream sample source for the audio PWM stage: plays one tone per request by stepping a phase accumulator and shaping it into 5-bit duty references (`pwm_ref`). New samples are issued only at PWM-period boundaries, so the downstream comparator never sees a mid-period duty change. It runs on the system clock, advanced by the divided-clock enable pulse `tick`.

## Interface
Parameters:
- `SAMPLE_W`, 5: sample / `pwm_ref` width; equals the PWM counter width.
- `PHASE_W`, 16: phase accumulator and `step` width.
- `DUR_W`, 16: width of `duration` (sample count).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `tick`  in  1  one-cycle enable; one PWM counter step.
- `start`  in  1  tone request; sampled only in IDLE.
- `step`  in  PHASE_W  phase increment per sample.
- `duration`  in  DUR_W  number of samples to play.
- `wave_sel`  in  2  00 square, 01 triangle, 10 sawtooth, 11 silence.
- `busy`  out  1  high in PLAY and DONE.
- `done`  out  1  one-cycle pulse at tone end.
- `pwm_ref`  out  SAMPLE_W  duty reference to the PWM stage.
- `sample_strobe`  out  1  one-cycle pulse when `pwm_ref` is loaded with a sample.

## Operation
- Slot counter: 5-bit and free-running. It increments on `tick` and wraps 31→0 in every state.
- Boundary: `tick && slot==31`. This aligns with the PWM counter wrap because both start at 0 from reset.
- States:
  - IDLE → PLAY on `start`. Latch `step`, `duration` into `remaining`, and `wave_sel`. Clear `phase` to 0.
  - PLAY, on each boundary:
    - if `remaining==0`, go to DONE and load `pwm_ref` with 0;
    - otherwise load `pwm_ref` with shape(`phase`), pulse `sample_strobe`, set `phase += step` (modulo 2^PHASE_W), and set `remaining -= 1`.
  - DONE lasts one cycle with `done`=1, then returns to IDLE.
- Shaping uses `phase` before the increment:
  - Square: `phase[15]` ? 31 : 0.
  - Sawtooth: `phase[15:11]`.
  - Triangle: with q = `phase[14:10]`, output q when `phase[15]`=0, otherwise 31−q.
  - Silence: 0.
- `start` is ignored in PLAY and DONE. Latched parameters do not change mid-tone.
- `duration`=0 gives no samples; the tone ends at the first boundary.
- In IDLE, `pwm_ref` holds 0.

## Timing
- Reset values: `pwm_ref`=0, `busy`=0, `done`=0, `sample_strobe`=0, `slot`=0, `phase`=0, state IDLE.
- Reset mid-tone returns to IDLE with the values above on the next edge.
- All outputs are registered.
- `pwm_ref` and `sample_strobe` update on the edge that samples the boundary. The value then holds for exactly 32 ticks.
- `busy` rises on the edge after `start` is seen in IDLE. It falls on the edge leaving DONE, which is the same edge `done` deasserts.
- First sample appears at the first boundary after entering PLAY, with latency 1–32 ticks.
- `start` on the same cycle as a boundary: the boundary is not used. The first sample waits for the next boundary.
- `reset` has priority over `start` and `tick`.

## Structure
- Package `audio_pkg`:
  - `SAMPLE_W`;
  - `wave_sel` encodings (WAVE_SQUARE, WAVE_TRI, WAVE_SAW, WAVE_SILENT);
  - state enum (ST_IDLE, ST_PLAY, ST_DONE).
- Sub-module `wave_shaper`: combinational, `phase[15:10]` + `wave_sel` → 5-bit sample. It is instantiated once.
- The parent holds the slot counter, FSM, accumulator and output registers.

## Test plan
- Reset, then 100 idle cycles with `tick` every 4 clocks → `pwm_ref`=0, `busy`=0, `done`=0, no `sample_strobe`.
- Square, `step`=0x4000, `duration`=8:
  - `pwm_ref` sequence 0,0,31,31,0,0,31,31;
  - strobes exactly 32 ticks apart, each on a boundary;
  - `done` is a single pulse at the 9th boundary, then `pwm_ref`=0 and `busy`=0.
- Triangle, `step`=0x0800, `duration`=20 → 0,2,4,…,30 then 31,29,27,25.
- Sawtooth, `step`=0x0800, `duration`=4 → 0,1,2,3.
- `duration`=0 → no strobe; `done` pulses one cycle after the first boundary following `start`.
- Robustness:
  - a second `start` mid-tone with different `step` is ignored and the sequence is unchanged;
  - `reset` asserted mid-tone → next edge gives `pwm_ref`=0 and `busy`=0;
  - a later `start` replays from `phase` 0.
